// File: rtl/hdmi_link_sequencer.sv
// Bring-up/recovery sequencer for the QSFP-HDMI output link: HPD debounce, module reset, retimer config, GT TX wait.
// Optional build macro HDMI_SEQ_DROP_COUNTER_EN adds a saturating count of link drops out of RUN.
//
// state   | meaning
// IDLE    | no sink; module held in reset
// RESET   | module_resetl held low for RESET_HOLD_CYCLES
// INIT    | module released; settle for INIT_WAIT_CYCLES
// CONFIG  | config engine started; wait for done/error/timeout
// WAIT_TX | waiting for the GT TX reset to release
// RUN     | link up
// BACKOFF | gap after a failed config attempt before retrying
// FAULT   | retries exhausted; leave only on HPD loss
module hdmi_link_sequencer #(
    parameter int DEBOUNCE_CYCLES       = 2_000_000,
    parameter int RESET_HOLD_CYCLES     = 400_000,
    parameter int INIT_WAIT_CYCLES      = 60_000_000,
    parameter int CONFIG_TIMEOUT_CYCLES = 20_000_000,
    parameter int BACKOFF_CYCLES        = 2_000_000,
    parameter int MAX_RETRIES           = 3
) (
    input  logic        system_clock,
    input  logic        system_reset_n,
    input  logic        hpd_raw,
    input  logic        tx_reset_raw,
    input  logic        config_done,
    input  logic        config_error,
    output logic        module_resetl,
    output logic        config_start,
    output logic        run,
    output logic        hpd_stable,
    output logic        fault,
    output logic [2:0]  state
`ifdef HDMI_SEQ_DROP_COUNTER_EN
    ,
    output logic [7:0]  drop_count
`endif
);

    localparam int MAX_AB  = (RESET_HOLD_CYCLES > INIT_WAIT_CYCLES) ? RESET_HOLD_CYCLES : INIT_WAIT_CYCLES;
    localparam int MAX_CD  = (CONFIG_TIMEOUT_CYCLES > BACKOFF_CYCLES) ? CONFIG_TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;
    localparam int DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESET   = 3'd1,
        INIT    = 3'd2,
        CONFIG  = 3'd3,
        WAIT_TX = 3'd4,
        RUN     = 3'd5,
        BACKOFF = 3'd6,
        FAULT   = 3'd7
    } state_t;

    logic [1:0]    hpd_ff;
    logic [1:0]    tx_ff;
    logic          hpd_sync;
    logic          tx_sync;
    logic [DW-1:0] db_cnt;
    state_t        state_q;
    state_t        nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_load;
    logic          timer_done;
    logic [3:0]    retry_cnt;
    logic [3:0]    retry_nxt;
    logic [3:0]    retry_inc;

    assign hpd_sync   = hpd_ff[1];
    assign tx_sync    = tx_ff[1];
    assign timer_done = (timer == '0);
    assign retry_inc  = retry_cnt + 4'd1;
    assign state      = state_q;

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            hpd_ff     <= '0;
            tx_ff      <= '0;
            db_cnt     <= '0;
            hpd_stable <= 1'b0;
        end else begin
            hpd_ff <= {hpd_ff[0], hpd_raw};
            tx_ff  <= {tx_ff[0], tx_reset_raw};
            if (hpd_sync == hpd_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                hpd_stable <= ~hpd_stable;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // HPD loss overrides everything; in CONFIG an error beats done, and done beats a same-cycle timeout.
    always_comb begin
        nxt       = state_q;
        retry_nxt = retry_cnt;
        if (!hpd_stable && state_q != IDLE) begin
            nxt       = IDLE;
            retry_nxt = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hpd_stable) begin
                        nxt       = RESET;
                        retry_nxt = '0;
                    end
                end
                RESET:   if (timer_done) nxt = INIT;
                INIT:    if (timer_done) nxt = CONFIG;
                CONFIG: begin
                    if (config_error || (timer_done && !config_done)) begin
                        retry_nxt = retry_inc;
                        nxt       = (retry_inc == MAX_R) ? FAULT : BACKOFF;
                    end else if (config_done) begin
                        nxt = WAIT_TX;
                    end
                end
                WAIT_TX: if (!tx_sync) nxt = RUN;
                RUN:     if (tx_sync) nxt = WAIT_TX;
                BACKOFF: if (timer_done) nxt = RESET;
                FAULT:   nxt = FAULT;
                default: nxt = IDLE;
            endcase
        end
    end

    // Timer is loaded with N-1 on state entry and expires at zero, giving N cycles in state.
    always_comb begin
        case (nxt)
            RESET:   timer_load = TW'(RESET_HOLD_CYCLES - 1);
            INIT:    timer_load = TW'(INIT_WAIT_CYCLES - 1);
            CONFIG:  timer_load = TW'(CONFIG_TIMEOUT_CYCLES - 1);
            BACKOFF: timer_load = TW'(BACKOFF_CYCLES - 1);
            default: timer_load = '0;
        endcase
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q       <= IDLE;
            timer         <= '0;
            retry_cnt     <= '0;
            module_resetl <= 1'b0;
            config_start  <= 1'b0;
            run           <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_q   <= nxt;
            retry_cnt <= retry_nxt;
            if (nxt != state_q) begin
                timer <= timer_load;
            end else if (!timer_done) begin
                timer <= timer - TW'(1);
            end
            module_resetl <= !(nxt == IDLE || nxt == RESET);
            config_start  <= (nxt == CONFIG) && (state_q != CONFIG);
            run           <= (nxt == RUN);
            fault         <= (nxt == FAULT);
        end
    end

`ifdef HDMI_SEQ_DROP_COUNTER_EN
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            drop_count <= '0;
        end else if (state_q == RUN && nxt != RUN && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule
